// File: rtl/icu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | icu_pkg: shared constants, FSM state type and geometry helpers for the ICU |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package icu_pkg;

   localparam int LINE_BYTES      = 32;
   localparam int WORDS_PER_LINE  = 4;
   localparam int WORD_BITS       = 64;
   localparam int ADDR_BITS       = 32;
   localparam int OFFSET_BITS     = $clog2(LINE_BYTES);
   localparam int WORD_SEL_BITS   = $clog2(WORDS_PER_LINE);
   // Fetch addresses drop the byte-within-word bits.
   localparam int FETCH_ADDR_BITS = ADDR_BITS - (OFFSET_BITS - WORD_SEL_BITS);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_MISS_REQ = 2'd1,
      ST_FILL     = 2'd2
   } icu_state_e;

   function automatic int index_width(input int index_bits);
      return index_bits;
   endfunction

   function automatic int tag_width(input int index_bits);
      return ADDR_BITS - index_bits - OFFSET_BITS;
   endfunction

endpackage
`default_nettype wire

// File: rtl/icu_line_array.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | icu_line_array: valid/tag/data storage of the direct-mapped line array     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module icu_line_array
   import icu_pkg::*;
#(
   parameter int INDEX_BITS = 7,
   parameter int TAG_BITS   = 20
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [INDEX_BITS-1:0]    i_rd_index,
   input  logic [WORD_SEL_BITS-1:0] i_rd_word,
   output logic                     o_rd_valid,
   output logic [TAG_BITS-1:0]      o_rd_tag,
   output logic [WORD_BITS-1:0]     o_rd_data,
   input  logic                     i_beat_we,
   input  logic [INDEX_BITS-1:0]    i_beat_index,
   input  logic [WORD_SEL_BITS-1:0] i_beat_word,
   input  logic [WORD_BITS-1:0]     i_beat_data,
   input  logic                     i_tag_we,
   input  logic [INDEX_BITS-1:0]    i_tag_index,
   input  logic [TAG_BITS-1:0]      i_tag_value,
   input  logic                     i_tag_valid
);

   localparam int SETS = 1 << INDEX_BITS;

   logic [SETS-1:0]      valid_q, valid_d;
   logic [TAG_BITS-1:0]  tag_q  [SETS];
   logic [WORD_BITS-1:0] data_q [SETS][WORDS_PER_LINE];

   always_comb begin
      valid_d = valid_q;
      if (i_tag_we) begin
         valid_d[i_tag_index] = i_tag_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
      end else begin
         valid_q <= valid_d;
      end
   end

   // Tag and data contents are qualified by the valid bit, so they need no reset.
   always_ff @(posedge clk) begin
      if (i_tag_we) begin
         tag_q[i_tag_index] <= i_tag_value;
      end
      if (i_beat_we) begin
         data_q[i_beat_index][i_beat_word] <= i_beat_data;
      end
   end

   assign o_rd_valid = valid_q[i_rd_index];
   assign o_rd_tag   = tag_q[i_rd_index];
   assign o_rd_data  = data_q[i_rd_index][i_rd_word];

endmodule
`default_nettype wire

// File: rtl/icu_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | icu_core: direct-mapped instruction cache, ic1/ic2 lookup and line refill  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module icu_core
   import icu_pkg::*;
#(
   parameter int INDEX_BITS = 7
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       ifu_icu_req_ic1,
   input  logic [FETCH_ADDR_BITS-1:0] ifu_icu_addr_ic1,
   output logic                       icu_ifu_ack_ic1,
   output logic                       icu_ifu_data_valid_ic2,
   output logic [WORD_BITS-1:0]       icu_ifu_data_ic2,
   output logic                       icu_biu_req,
   output logic [ADDR_BITS-1:0]       icu_biu_addr,
   input  logic                       biu_icu_ack,
   input  logic                       biu_icu_data_valid,
   input  logic [WORD_BITS-1:0]       biu_icu_data,
   input  logic                       biu_icu_data_last
);

   localparam int IDX_W   = index_width(INDEX_BITS);
   localparam int TAG_W   = tag_width(INDEX_BITS);
   localparam int LINE_W  = TAG_W + IDX_W;
   localparam int IDX_LSB = WORD_SEL_BITS;
   localparam int TAG_LSB = WORD_SEL_BITS + IDX_W;

   icu_state_e                 state_q, state_d;
   logic                       ic2_valid_q, ic2_valid_d;
   logic [FETCH_ADDR_BITS-1:0] ic2_addr_q, ic2_addr_d;
   logic [LINE_W-1:0]          miss_line_q, miss_line_d;
   logic [WORD_SEL_BITS-1:0]   cnt_q, cnt_d;

   logic                       w_rd_valid;
   logic [TAG_W-1:0]           w_rd_tag;
   logic [WORD_BITS-1:0]       w_rd_data;
   logic                       w_ic2_hit;
   logic                       w_ic2_miss;
   logic                       w_beat_we;
   logic                       w_tag_we;
   logic                       w_tag_valid;

   icu_line_array #(
      .INDEX_BITS (IDX_W),
      .TAG_BITS   (TAG_W)
   ) u_line_array (
      .clk          (clk),
      .rst          (reset),
      .i_rd_index   (ic2_addr_q[TAG_LSB-1:IDX_LSB]),
      .i_rd_word    (ic2_addr_q[WORD_SEL_BITS-1:0]),
      .o_rd_valid   (w_rd_valid),
      .o_rd_tag     (w_rd_tag),
      .o_rd_data    (w_rd_data),
      .i_beat_we    (w_beat_we),
      .i_beat_index (miss_line_q[IDX_W-1:0]),
      .i_beat_word  (cnt_q),
      .i_beat_data  (biu_icu_data),
      .i_tag_we     (w_tag_we),
      .i_tag_index  (miss_line_q[IDX_W-1:0]),
      .i_tag_value  (miss_line_q[LINE_W-1:IDX_W]),
      .i_tag_valid  (w_tag_valid)
   );

   assign w_ic2_hit  = ic2_valid_q & w_rd_valid
                     & (w_rd_tag == ic2_addr_q[FETCH_ADDR_BITS-1:TAG_LSB]);
   assign w_ic2_miss = ic2_valid_q & ~w_ic2_hit;

   always_comb begin
      state_d         = state_q;
      ic2_valid_d     = 1'b0;
      ic2_addr_d      = ic2_addr_q;
      miss_line_d     = miss_line_q;
      cnt_d           = cnt_q;
      icu_ifu_ack_ic1 = 1'b0;
      icu_biu_req     = 1'b0;
      w_beat_we       = 1'b0;
      w_tag_we        = 1'b0;
      w_tag_valid     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // A miss sitting in ic2 blocks the request behind it.
            icu_ifu_ack_ic1 = ifu_icu_req_ic1 & ~w_ic2_miss;
            if (icu_ifu_ack_ic1) begin
               ic2_valid_d = 1'b1;
               ic2_addr_d  = ifu_icu_addr_ic1;
            end
            if (w_ic2_miss) begin
               state_d     = ST_MISS_REQ;
               miss_line_d = ic2_addr_q[FETCH_ADDR_BITS-1:IDX_LSB];
            end
         end
         ST_MISS_REQ: begin
            icu_biu_req = 1'b1;
            if (biu_icu_ack) begin
               state_d  = ST_FILL;
               cnt_d    = '0;
               // The set is being overwritten; drop its old contents up front.
               w_tag_we = 1'b1;
            end
         end
         ST_FILL: begin
            if (biu_icu_data_valid) begin
               w_beat_we = 1'b1;
               cnt_d     = cnt_q + 1'b1;
               if (biu_icu_data_last) begin
                  w_tag_we    = 1'b1;
                  w_tag_valid = 1'b1;
                  cnt_d       = '0;
                  state_d     = ST_IDLE;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         ic2_valid_q <= 1'b0;
         ic2_addr_q  <= '0;
         miss_line_q <= '0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         ic2_valid_q <= ic2_valid_d;
         ic2_addr_q  <= ic2_addr_d;
         miss_line_q <= miss_line_d;
         cnt_q       <= cnt_d;
      end
   end

   assign icu_ifu_data_valid_ic2 = w_ic2_hit;
   assign icu_ifu_data_ic2       = w_ic2_hit ? w_rd_data : '0;
   assign icu_biu_addr           = icu_biu_req ? {miss_line_q, {OFFSET_BITS{1'b0}}} : '0;

endmodule
`default_nettype wire

// File: tb/tb_icu_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_icu_core: directed plus randomized bench with a line-level cache model  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_icu_core;

   localparam int IB    = 7;
   localparam int SETS  = 1 << IB;
   localparam int TAG_W = 29 - IB - 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        req;
   logic [28:0] addr;
   logic        ack;
   logic        dvalid;
   logic [63:0] dword;
   logic        biu_req;
   logic [31:0] biu_addr;
   logic        biu_ack;
   logic        bdv;
   logic [63:0] bdata;
   logic        blast;

   int n_cmp  = 0;
   int n_fail = 0;

   icu_core #(.INDEX_BITS(IB)) dut (
      .clk                    (clk),
      .reset                  (reset),
      .ifu_icu_req_ic1        (req),
      .ifu_icu_addr_ic1       (addr),
      .icu_ifu_ack_ic1        (ack),
      .icu_ifu_data_valid_ic2 (dvalid),
      .icu_ifu_data_ic2       (dword),
      .icu_biu_req            (biu_req),
      .icu_biu_addr           (biu_addr),
      .biu_icu_ack            (biu_ack),
      .biu_icu_data_valid     (bdv),
      .biu_icu_data           (bdata),
      .biu_icu_data_last      (blast)
   );

   always #5 clk = ~clk;

   // Model: cache contents, the one outstanding fetch in ic2, and refill progress
   // (0 = none, 1 = waiting for BIU acceptance, 2 = collecting beats).
   bit                m_valid [SETS];
   logic [TAG_W-1:0]  m_tag   [SETS];
   logic [63:0]       m_data  [SETS][4];
   bit                m_ic2_v;
   logic [28:0]       m_ic2_a;
   int                m_phase;
   logic [TAG_W+IB-1:0] m_line;
   logic [63:0]       m_beats [$];
   bit                chk_en = 1'b0;

   function automatic logic [IB-1:0] f_idx(input logic [28:0] a);
      return a[IB+1:2];
   endfunction

   function automatic logic [TAG_W-1:0] f_tag(input logic [28:0] a);
      return a[28:IB+2];
   endfunction

   function automatic bit m_hit();
      return m_ic2_v && m_valid[f_idx(m_ic2_a)] && (m_tag[f_idx(m_ic2_a)] == f_tag(m_ic2_a));
   endfunction

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      bit hit, miss, acc;
      if (reset) begin
         for (int s = 0; s < SETS; s++) m_valid[s] = 1'b0;
         m_phase = 0;
         m_ic2_v = 1'b0;
         m_beats.delete();
         chk_en  = 1'b1;
      end else if (chk_en) begin
         hit  = m_hit();
         miss = m_ic2_v && !hit;
         acc  = req && (m_phase == 0) && !miss;
         case (m_phase)
            0: if (miss) begin
               m_phase = 1;
               m_line  = m_ic2_a[28:2];
            end
            1: if (biu_ack) begin
               m_phase = 2;
               m_beats.delete();
            end
            default: if (bdv) begin
               m_beats.push_back(bdata);
               if (blast) begin
                  for (int w = 0; w < 4; w++) m_data[m_line[IB-1:0]][w] = m_beats[w];
                  m_tag[m_line[IB-1:0]]   = m_line[TAG_W+IB-1:IB];
                  m_valid[m_line[IB-1:0]] = 1'b1;
                  m_phase = 0;
               end
            end
         endcase
         m_ic2_v = acc;
         m_ic2_a = addr;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         bit          hit;
         logic [63:0] exp_data;
         hit      = m_hit();
         exp_data = hit ? m_data[f_idx(m_ic2_a)][m_ic2_a[1:0]] : 64'd0;
         check("ack",        {63'd0, ack},     {63'd0, req && (m_phase == 0) && !(m_ic2_v && !hit)});
         check("data_valid", {63'd0, dvalid},  {63'd0, hit});
         check("data",       dword,            exp_data);
         check("biu_req",    {63'd0, biu_req}, {63'd0, m_phase == 1});
         check("biu_addr",   {32'd0, biu_addr}, (m_phase == 1) ? {32'd0, m_line, 5'd0} : 64'd0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [28:0] rand_addr();
      logic [28:0] a;
      a          = '0;
      a[28:IB+2] = TAG_W'($urandom_range(0, 2));
      a[IB+1:2]  = IB'($urandom_range(0, 3));
      a[1:0]     = 2'($urandom_range(0, 3));
      return a;
   endfunction

   logic [63:0] lw [4];

   initial begin
      lw[0] = 64'hbbbb_bbbb_bbbb_bbbb;
      lw[1] = 64'hcccc_cccc_cccc_cccc;
      lw[2] = 64'hdddd_dddd_dddd_dddd;
      lw[3] = 64'heeee_eeee_eeee_eeee;
      reset = 1'b1; req = 1'b0; addr = '0; biu_ack = 1'b0;
      bdv = 1'b0; bdata = '0; blast = 1'b0;
      repeat (3) tick();
      @(negedge clk);
      check("rst_ack", {63'd0, ack}, 64'd0);
      check("rst_dv", {63'd0, dvalid}, 64'd0);
      check("rst_data", dword, 64'd0);
      check("rst_biu_req", {63'd0, biu_req}, 64'd0);
      check("rst_biu_addr", {32'd0, biu_addr}, 64'd0);

      // Cold miss on 0x2021 and its refill, with a request held throughout.
      tick(); reset = 1'b0; req = 1'b1; addr = 29'h2021;
      @(negedge clk); check("first_ack", {63'd0, ack}, 64'd1);
      tick(); req = 1'b0;
      @(negedge clk); check("miss_dv", {63'd0, dvalid}, 64'd0);
      check("miss_no_req_yet", {63'd0, biu_req}, 64'd0);
      tick(); biu_ack = 1'b1;
      @(negedge clk); check("refill_req", {63'd0, biu_req}, 64'd1);
      check("refill_addr", {32'd0, biu_addr}, 64'h0001_0100);
      for (int i = 0; i < 4; i++) begin
         tick(); biu_ack = 1'b0; req = 1'b1; addr = 29'h2022;
         bdv = 1'b1; bdata = lw[i]; blast = (i == 3);
         @(negedge clk);
         check("fill_req_low", {63'd0, biu_req}, 64'd0);
         check("fill_no_ack", {63'd0, ack}, 64'd0);
         check("fill_no_dv", {63'd0, dvalid}, 64'd0);
      end
      tick(); bdv = 1'b0; blast = 1'b0;
      @(negedge clk); check("ack_after_last", {63'd0, ack}, 64'd1);
      tick(); addr = 29'h2020;
      @(negedge clk); check("hit_2022", dword, 64'hdddd_dddd_dddd_dddd);
      tick(); addr = 29'h2023;
      @(negedge clk); check("hit_2020", dword, 64'hbbbb_bbbb_bbbb_bbbb);
      tick(); req = 1'b0;
      @(negedge clk); check("hit_2023", dword, 64'heeee_eeee_eeee_eeee);

      // Same index, different tag replaces the line.
      tick(); req = 1'b1; addr = 29'h2221;
      @(negedge clk); check("conf_ack", {63'd0, ack}, 64'd1);
      tick(); req = 1'b0;
      @(negedge clk); check("conf_miss", {63'd0, dvalid}, 64'd0);
      tick(); biu_ack = 1'b1;
      @(negedge clk); check("conf_addr", {32'd0, biu_addr}, 64'h0001_1100);
      for (int i = 0; i < 4; i++) begin
         tick(); biu_ack = 1'b0; bdv = 1'b1;
         bdata = 64'h1111_1111_1111_1111 * (i + 1); blast = (i == 3);
      end
      tick(); bdv = 1'b0; blast = 1'b0; req = 1'b1; addr = 29'h2221;
      @(negedge clk); check("conf_ack2", {63'd0, ack}, 64'd1);
      tick(); addr = 29'h2021;
      @(negedge clk); check("conf_hit", dword, 64'h2222_2222_2222_2222);
      tick(); req = 1'b0;
      @(negedge clk); check("orig_miss", {63'd0, dvalid}, 64'd0);
      tick(); biu_ack = 1'b1;
      @(negedge clk); check("orig_addr", {32'd0, biu_addr}, 64'h0001_0100);

      // Abort the refill after two beats.
      tick(); biu_ack = 1'b0; bdv = 1'b1; bdata = 64'h5;
      tick(); bdata = 64'h6;
      tick(); bdv = 1'b0; reset = 1'b1;
      tick(); reset = 1'b0; req = 1'b1; addr = 29'h2021;
      @(negedge clk); check("abort_req_low", {63'd0, biu_req}, 64'd0);
      check("abort_ack", {63'd0, ack}, 64'd1);
      tick(); req = 1'b0;
      @(negedge clk); check("abort_miss", {63'd0, dvalid}, 64'd0);
      tick();
      @(negedge clk); check("abort_rereq", {63'd0, biu_req}, 64'd1);

      // Randomized traffic; the BIU side follows the model's refill progress.
      for (int c = 0; c < 4000; c++) begin
         tick();
         reset = ($urandom_range(0, 799) == 0);
         if (!reset && $urandom_range(0, 2) != 0) begin
            req = 1'b1;
            if ($urandom_range(0, 3) != 0) addr = rand_addr();
         end else begin
            req = 1'b0;
         end
         biu_ack = !reset && (m_phase == 1) && ($urandom_range(0, 1) == 1);
         if (m_phase == 2) begin
            bdv   = ($urandom_range(0, 2) != 0);
            blast = bdv && (m_beats.size() == 3);
         end else begin
            bdv   = ($urandom_range(0, 7) == 0);
            blast = bdv && ($urandom_range(0, 1) == 1);
         end
         bdata = {$urandom(), $urandom()};
      end
      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
